// File: rtl/offnariscv_pkg.sv
// Shared offnariscv payload types plus the execute-scheduler state and unit enums.
package offnariscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_cmd_e;

   typedef enum logic [2:0] {
      BRU_BEQ, BRU_BNE, BRU_BLT, BRU_BGE,
      BRU_BLTU, BRU_BGEU, BRU_JAL, BRU_JALR
   } bru_cmd_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
   } if_data_t;

   typedef struct packed {
      if_data_t        if_data;
      logic            int_exc_valid;
      logic            alu_cmd_vld;
      alu_cmd_e        alu_cmd;
      logic            bru_cmd_vld;
      bru_cmd_e        bru_cmd;
      logic [XLEN-1:0] operand1;
      logic [XLEN-1:0] operand2;
      logic [XLEN-1:0] immediate;
   } rfex_tdata_t;

   typedef struct packed {
      logic [XLEN-1:0] operand1;
      logic [XLEN-1:0] operand2;
      alu_cmd_e        cmd;
   } rfalu_tdata_t;

   typedef struct packed {
      logic [XLEN-1:0] result;
   } aluwb_tdata_t;

   typedef struct packed {
      logic [XLEN-1:0] operand1;
      logic [XLEN-1:0] operand2;
      logic [XLEN-1:0] offset;
      logic [XLEN-1:0] this_pc;
      bru_cmd_e        cmd;
   } rfbru_tdata_t;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] new_pc;
      logic            taken;
   } bruwb_tdata_t;

   typedef struct packed {
      rfex_tdata_t rf_data;
   } ex_data_t;

   typedef struct packed {
      logic [XLEN-1:0] wdata;
      ex_data_t        ex_data;
   } wbrf_tdata_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} ex_sched_state_e;

   typedef enum logic [1:0] {EXU_NONE, EXU_ALU, EXU_BRU} ex_unit_e;

   // A pending exception suppresses dispatch; BRU has priority over ALU.
   function automatic ex_unit_e ex_select_unit(input rfex_tdata_t beat);
      if (beat.int_exc_valid) return EXU_NONE;
      if (beat.bru_cmd_vld)   return EXU_BRU;
      if (beat.alu_cmd_vld)   return EXU_ALU;
      return EXU_NONE;
   endfunction

endpackage

// File: rtl/offnariscv_ex_sched.sv
// Execute-stage scheduler: one instruction in flight, dispatched to ALU or BRU, result to WB.
// Optional performance counters are enabled with `define OFFNARISCV_EX_SCHED_PERF_EN.
module offnariscv_ex_sched
   import offnariscv_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_rfex_tvalid,
   output logic                         s_rfex_tready,
   input  rfex_tdata_t                  s_rfex_tdata,
   output logic                         m_alu_tvalid,
   input  logic                         m_alu_tready,
   output rfalu_tdata_t                 m_alu_tdata,
   input  logic                         s_alu_tvalid,
   output logic                         s_alu_tready,
   input  aluwb_tdata_t                 s_alu_tdata,
   output logic                         m_bru_tvalid,
   input  logic                         m_bru_tready,
   output rfbru_tdata_t                 m_bru_tdata,
   input  logic                         s_bru_tvalid,
   output logic                         s_bru_tready,
   input  bruwb_tdata_t                 s_bru_tdata,
   output logic                         m_wb_tvalid,
   input  logic                         m_wb_tready,
   output wbrf_tdata_t                  m_wb_tdata,
   output logic                         redirect_valid,
   output logic [XLEN-1:0]              redirect_pc
`ifdef OFFNARISCV_EX_SCHED_PERF_EN
   ,
   output logic [31:0]                  perf_busy_cycles,
   output logic [31:0]                  perf_unit_stall_cycles,
   output logic [31:0]                  perf_wb_stall_cycles
`endif
);

   ex_sched_state_e state_q, state_d;
   ex_unit_e        sel_q, sel_d;
   rfex_tdata_t     beat_q, beat_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] new_pc_q, new_pc_d;
   logic            taken_q, taken_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   logic            rfex_fire;
   ex_unit_e        rfex_sel;

   // Readies are forced low while reset is held so nothing handshakes into a resetting block.
   assign s_rfex_tready = rst_n && ((state_q == IDLE) || ((state_q == OUT) && m_wb_tready));
   assign rfex_fire     = s_rfex_tvalid && s_rfex_tready;
   assign rfex_sel      = ex_select_unit(s_rfex_tdata);

   assign m_alu_tvalid  = (state_q == ISSUE) && (sel_q == EXU_ALU);
   assign m_bru_tvalid  = (state_q == ISSUE) && (sel_q == EXU_BRU);
   assign s_alu_tready  = (state_q == WAIT)  && (sel_q == EXU_ALU);
   assign s_bru_tready  = (state_q == WAIT)  && (sel_q == EXU_BRU);
   assign m_wb_tvalid   = (state_q == OUT);

   assign m_alu_tdata = '{operand1: beat_q.operand1, operand2: beat_q.operand2,
                          cmd: beat_q.alu_cmd};
   assign m_bru_tdata = '{operand1: beat_q.operand1, operand2: beat_q.operand2,
                          offset: beat_q.immediate, this_pc: beat_q.if_data.pc,
                          cmd: beat_q.bru_cmd};
   assign m_wb_tdata  = '{wdata: result_q, ex_data: '{rf_data: beat_q}};

   assign redirect_valid = m_wb_tvalid && m_wb_tready && (sel_q == EXU_BRU) && taken_q;
   assign redirect_pc    = redirect_valid ? new_pc_q : redirect_pc_q;

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      beat_d        = beat_q;
      result_d      = result_q;
      new_pc_d      = new_pc_q;
      taken_d       = taken_q;
      redirect_pc_d = redirect_pc_q;

      case (state_q)
         ISSUE: begin
            if ((m_alu_tvalid && m_alu_tready) || (m_bru_tvalid && m_bru_tready)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (s_alu_tready && s_alu_tvalid) begin
               result_d = s_alu_tdata.result;
               state_d  = OUT;
            end else if (s_bru_tready && s_bru_tvalid) begin
               result_d = s_bru_tdata.result;
               new_pc_d = s_bru_tdata.new_pc;
               taken_d  = s_bru_tdata.taken;
               state_d  = OUT;
            end
         end
         OUT: begin
            if (m_wb_tready) begin
               state_d = IDLE;
               if (redirect_valid) redirect_pc_d = new_pc_q;
            end
         end
         default: state_d = state_q;
      endcase

      // A new beat is only accepted in IDLE or on the OUT handshake, so it overrides the above.
      if (rfex_fire) begin
         beat_d = s_rfex_tdata;
         sel_d  = rfex_sel;
         if (rfex_sel == EXU_NONE) begin
            result_d = '0;
            state_d  = OUT;
         end else begin
            state_d  = ISSUE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sel_q         <= EXU_NONE;
         beat_q        <= '0;
         result_q      <= '0;
         new_pc_q      <= '0;
         taken_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         beat_q        <= beat_d;
         result_q      <= result_d;
         new_pc_q      <= new_pc_d;
         taken_q       <= taken_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

`ifdef OFFNARISCV_EX_SCHED_PERF_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [31:0] perf_unit_q, perf_unit_d;
   logic [31:0] perf_wb_q, perf_wb_d;
   logic        unit_stall;

   assign unit_stall = ((state_q == ISSUE) && !((sel_q == EXU_ALU) ? m_alu_tready : m_bru_tready))
                    || ((state_q == WAIT)  && !((sel_q == EXU_ALU) ? s_alu_tvalid : s_bru_tvalid));

   always_comb begin
      perf_busy_d = perf_busy_q;
      perf_unit_d = perf_unit_q;
      perf_wb_d   = perf_wb_q;
      if (state_q != IDLE)                 perf_busy_d = perf_busy_q + 32'd1;
      if (unit_stall)                      perf_unit_d = perf_unit_q + 32'd1;
      if ((state_q == OUT) && !m_wb_tready) perf_wb_d  = perf_wb_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_q <= '0;
         perf_unit_q <= '0;
         perf_wb_q   <= '0;
      end else begin
         perf_busy_q <= perf_busy_d;
         perf_unit_q <= perf_unit_d;
         perf_wb_q   <= perf_wb_d;
      end
   end

   assign perf_busy_cycles       = perf_busy_q;
   assign perf_unit_stall_cycles = perf_unit_q;
   assign perf_wb_stall_cycles   = perf_wb_q;

`ifndef SYNTHESIS
   dual_cmd_a: assert property (@(posedge clk) disable iff (!rst_n)
      rfex_fire |-> !(s_rfex_tdata.alu_cmd_vld && s_rfex_tdata.bru_cmd_vld));
`endif
`endif

endmodule

// File: tb/tb_offnariscv_ex_sched.sv
// Self-checking bench for offnariscv_ex_sched: ALU/BRU responders plus a writeback scoreboard.
module tb_offnariscv_ex_sched;
   import offnariscv_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_rfex_tvalid, s_rfex_tready;
   rfex_tdata_t  s_rfex_tdata;
   logic         m_alu_tvalid, m_alu_tready;
   rfalu_tdata_t m_alu_tdata;
   logic         s_alu_tvalid, s_alu_tready;
   aluwb_tdata_t s_alu_tdata;
   logic         m_bru_tvalid, m_bru_tready;
   rfbru_tdata_t m_bru_tdata;
   logic         s_bru_tvalid, s_bru_tready;
   bruwb_tdata_t s_bru_tdata;
   logic         m_wb_tvalid, m_wb_tready;
   wbrf_tdata_t  m_wb_tdata;
   logic         redirect_valid;
   logic [XLEN-1:0] redirect_pc;
`ifdef OFFNARISCV_EX_SCHED_PERF_EN
   logic [31:0]  perf_busy_cycles, perf_unit_stall_cycles, perf_wb_stall_cycles;
`endif

   offnariscv_ex_sched dut (
      .clk(clk), .rst_n(rst_n),
      .s_rfex_tvalid(s_rfex_tvalid), .s_rfex_tready(s_rfex_tready), .s_rfex_tdata(s_rfex_tdata),
      .m_alu_tvalid(m_alu_tvalid), .m_alu_tready(m_alu_tready), .m_alu_tdata(m_alu_tdata),
      .s_alu_tvalid(s_alu_tvalid), .s_alu_tready(s_alu_tready), .s_alu_tdata(s_alu_tdata),
      .m_bru_tvalid(m_bru_tvalid), .m_bru_tready(m_bru_tready), .m_bru_tdata(m_bru_tdata),
      .s_bru_tvalid(s_bru_tvalid), .s_bru_tready(s_bru_tready), .s_bru_tdata(s_bru_tdata),
      .m_wb_tvalid(m_wb_tvalid), .m_wb_tready(m_wb_tready), .m_wb_tdata(m_wb_tdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef OFFNARISCV_EX_SCHED_PERF_EN
      , .perf_busy_cycles(perf_busy_cycles), .perf_unit_stall_cycles(perf_unit_stall_cycles),
      .perf_wb_stall_cycles(perf_wb_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      wbrf_tdata_t     data;
      logic            redir;
      logic [XLEN-1:0] pc;
   } wb_exp_t;

   wb_exp_t      wb_q[$];
   rfalu_tdata_t alu_req_q[$];
   aluwb_tdata_t alu_res_q[$];
   rfbru_tdata_t bru_req_q[$];
   bruwb_tdata_t bru_res_q[$];

   int checks = 0;
   int errors = 0;
   int wb_seen = 0;
   int exp_beats = 0;
   int alu_delay = 0;

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic rfex_tdata_t mkBeat(input logic [XLEN-1:0] pc, input logic exc,
                                          input logic alu_vld, input alu_cmd_e alu_cmd,
                                          input logic bru_vld, input bru_cmd_e bru_cmd,
                                          input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2,
                                          input logic [XLEN-1:0] imm);
      rfex_tdata_t b;
      b.if_data.pc    = pc;
      b.int_exc_valid = exc;
      b.alu_cmd_vld   = alu_vld;
      b.alu_cmd       = alu_cmd;
      b.bru_cmd_vld   = bru_vld;
      b.bru_cmd       = bru_cmd;
      b.operand1      = op1;
      b.operand2      = op2;
      b.immediate     = imm;
      return b;
   endfunction

   function automatic rfalu_tdata_t expAluReq(input rfex_tdata_t b);
      rfalu_tdata_t r;
      r.operand1 = b.operand1;
      r.operand2 = b.operand2;
      r.cmd      = b.alu_cmd;
      return r;
   endfunction

   function automatic bruwb_tdata_t mkBru(input logic [XLEN-1:0] res, input logic [XLEN-1:0] npc,
                                          input logic tk);
      bruwb_tdata_t r;
      r.result = res;
      r.new_pc = npc;
      r.taken  = tk;
      return r;
   endfunction

   // Drive one RF beat, record what the units and writeback must see, wait for its acceptance.
   task automatic applyStimulus(input rfex_tdata_t beat, input logic [XLEN-1:0] alu_res,
                                input bruwb_tdata_t bru_res, output logic in_out);
      wb_exp_t      e;
      rfbru_tdata_t br;
      aluwb_tdata_t aw;
      logic         got;
      e.data.ex_data.rf_data = beat;
      e.redir = 1'b0;
      e.pc    = '0;
      if (beat.int_exc_valid || !(beat.alu_cmd_vld || beat.bru_cmd_vld)) begin
         e.data.wdata = '0;
      end else if (beat.bru_cmd_vld) begin
         e.data.wdata = bru_res.result;
         e.redir      = bru_res.taken;
         e.pc         = bru_res.new_pc;
         br.operand1  = beat.operand1;
         br.operand2  = beat.operand2;
         br.offset    = beat.immediate;
         br.this_pc   = beat.if_data.pc;
         br.cmd       = beat.bru_cmd;
         bru_req_q.push_back(br);
         bru_res_q.push_back(bru_res);
      end else begin
         e.data.wdata = alu_res;
         alu_req_q.push_back(expAluReq(beat));
         aw.result = alu_res;
         alu_res_q.push_back(aw);
      end
      wb_q.push_back(e);
      exp_beats++;
      s_rfex_tdata  = beat;
      s_rfex_tvalid = 1'b1;
      got    = 1'b0;
      in_out = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         got    = s_rfex_tready;
         in_out = m_wb_tvalid;
         @(posedge clk); #2;
      end
      s_rfex_tvalid = 1'b0;
      if (!got) checkOutput("rfex_accept_timeout", 256'(0), 256'(1));
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic drainPipe(input string tag);
      int n = 0;
      while ((wb_q.size() != 0 || m_wb_tvalid) && n < 60) begin
         @(posedge clk); #2;
         n++;
      end
      checkOutput(tag, 256'(wb_q.size()), 256'(0));
   endtask

   // ALU model: checks each request payload and returns the queued result after alu_delay cycles.
   initial begin : alu_resp
      int cnt;
      logic req_fire, res_fire;
      rfalu_tdata_t req_exp;
      cnt = -1;
      s_alu_tvalid = 1'b0;
      s_alu_tdata  = '0;
      forever begin
         @(negedge clk);
         req_fire = rst_n && m_alu_tvalid && m_alu_tready;
         res_fire = rst_n && s_alu_tvalid && s_alu_tready;
         if (req_fire) begin
            if (alu_req_q.size() == 0) checkOutput("alu_req_unexpected", 256'(1), 256'(0));
            else begin
               req_exp = alu_req_q.pop_front();
               checkOutput("alu_req_payload", 256'(m_alu_tdata), 256'(req_exp));
            end
         end
         @(posedge clk); #2;
         if (!rst_n) begin
            s_alu_tvalid = 1'b0;
            cnt = -1;
            alu_req_q.delete();
            alu_res_q.delete();
            continue;
         end
         if (res_fire) s_alu_tvalid = 1'b0;
         if (req_fire) cnt = alu_delay;
         if (cnt == 0) begin
            s_alu_tvalid = 1'b1;
            s_alu_tdata  = (alu_res_q.size() != 0) ? alu_res_q.pop_front() : '0;
            cnt = -1;
         end else if (cnt > 0) begin
            cnt--;
         end
      end
   end

   // BRU model: answers in the cycle after the request handshake.
   initial begin : bru_resp
      logic req_fire, res_fire;
      rfbru_tdata_t req_exp;
      s_bru_tvalid = 1'b0;
      s_bru_tdata  = '0;
      forever begin
         @(negedge clk);
         req_fire = rst_n && m_bru_tvalid && m_bru_tready;
         res_fire = rst_n && s_bru_tvalid && s_bru_tready;
         if (req_fire) begin
            if (bru_req_q.size() == 0) checkOutput("bru_req_unexpected", 256'(1), 256'(0));
            else begin
               req_exp = bru_req_q.pop_front();
               checkOutput("bru_req_payload", 256'(m_bru_tdata), 256'(req_exp));
            end
         end
         @(posedge clk); #2;
         if (!rst_n) begin
            s_bru_tvalid = 1'b0;
            bru_req_q.delete();
            bru_res_q.delete();
            continue;
         end
         if (res_fire) s_bru_tvalid = 1'b0;
         if (req_fire) begin
            s_bru_tvalid = 1'b1;
            s_bru_tdata  = (bru_res_q.size() != 0) ? bru_res_q.pop_front() : '0;
         end
      end
   end

   // Writeback scoreboard; redirect must pulse only alongside a taken-branch wb handshake.
   initial begin : wb_mon
      wb_exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (m_wb_tvalid && m_wb_tready) begin
            wb_seen++;
            if (wb_q.size() == 0) checkOutput("wb_unexpected", 256'(1), 256'(0));
            else begin
               e = wb_q.pop_front();
               checkOutput("wb_wdata", 256'(m_wb_tdata.wdata), 256'(e.data.wdata));
               checkOutput("wb_rf_data", 256'(m_wb_tdata.ex_data.rf_data), 256'(e.data.ex_data.rf_data));
               checkOutput("redir_valid", 256'(redirect_valid), 256'(e.redir));
               if (e.redir) checkOutput("redir_pc", 256'(redirect_pc), 256'(e.pc));
            end
         end else begin
            checkOutput("redir_idle", 256'(redirect_valid), 256'(0));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      rfex_tdata_t  b;
      logic         in_out;
      logic [XLEN-1:0] op1, op2;
      rst_n         = 1'b0;
      s_rfex_tvalid = 1'b0;
      s_rfex_tdata  = '0;
      m_alu_tready  = 1'b1;
      m_bru_tready  = 1'b1;
      m_wb_tready   = 1'b1;
      #1;
      checkOutput("rst_rfex_tready", 256'(s_rfex_tready), 256'(0));
      checkOutput("rst_wb_tvalid", 256'(m_wb_tvalid), 256'(0));
      checkOutput("rst_redirect_pc", 256'(redirect_pc), 256'(0));
      checkOutput("rst_wb_tdata", 256'(m_wb_tdata), 256'(0));
      waitCycles(3);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_rfex_tready", 256'(s_rfex_tready), 256'(1));
      waitCycles(1);

      $display("[TB] ALU add latency");
      op1 = 32'd5; op2 = 32'd7;
      b = mkBeat(32'h80, 1'b0, 1'b1, ALU_ADD, 1'b0, BRU_BEQ, op1, op2, 32'h0);
      applyStimulus(b, op1 + op2, mkBru(0, 0, 0), in_out);
      @(negedge clk);
      checkOutput("alu_lat_issue", 256'(m_alu_tvalid), 256'(1));
      @(negedge clk);
      checkOutput("alu_lat_wait", 256'(s_alu_tready), 256'(1));
      checkOutput("alu_lat_bru_rdy", 256'(s_bru_tready), 256'(0));
      @(negedge clk);
      checkOutput("alu_lat_out", 256'(m_wb_tvalid), 256'(1));
      waitCycles(1);
      drainPipe("drain_alu_add");

      $display("[TB] taken BEQ");
      b = mkBeat(32'h100, 1'b0, 1'b0, ALU_ADD, 1'b1, BRU_BEQ, 32'd3, 32'd3, 32'h20);
      applyStimulus(b, 0, mkBru(32'h0, 32'h120, 1'b1), in_out);
      drainPipe("drain_beq");
      waitCycles(1);
      checkOutput("beq_redir_hold", 256'(redirect_pc), 256'(32'h120));

      $display("[TB] not-taken BNE");
      b = mkBeat(32'h140, 1'b0, 1'b0, ALU_ADD, 1'b1, BRU_BNE, 32'd3, 32'd3, 32'h40);
      applyStimulus(b, 0, mkBru(32'h0, 32'h144, 1'b0), in_out);
      drainPipe("drain_bne");
      waitCycles(1);
      checkOutput("bne_redir_hold", 256'(redirect_pc), 256'(32'h120));

      $display("[TB] exception beat");
      b = mkBeat(32'h180, 1'b1, 1'b1, ALU_ADD, 1'b0, BRU_BEQ, 32'd1, 32'd2, 32'h0);
      applyStimulus(b, 32'd3, mkBru(0, 0, 0), in_out);
      @(negedge clk);
      checkOutput("exc_wb_tvalid", 256'(m_wb_tvalid), 256'(1));
      checkOutput("exc_no_alu", 256'(m_alu_tvalid), 256'(0));
      waitCycles(1);
      drainPipe("drain_exc");

      $display("[TB] backpressure");
      m_alu_tready = 1'b0;
      b = mkBeat(32'h1c0, 1'b0, 1'b1, ALU_SUB, 1'b0, BRU_BEQ, 32'd9, 32'd4, 32'h0);
      applyStimulus(b, 32'd5, mkBru(0, 0, 0), in_out);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("bp_alu_tvalid", 256'(m_alu_tvalid), 256'(1));
         checkOutput("bp_alu_tdata", 256'(m_alu_tdata), 256'(expAluReq(b)));
         checkOutput("bp_rfex_tready", 256'(s_rfex_tready), 256'(0));
      end
      @(posedge clk); #2;
      m_alu_tready = 1'b1;
      m_wb_tready  = 1'b0;
      for (int n = 0; n < 20 && !m_wb_tvalid; n++) @(negedge clk);
      checkOutput("bp_wb_reached", 256'(m_wb_tvalid), 256'(1));
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         checkOutput("bp_wb_hold", 256'(m_wb_tvalid), 256'(1));
         checkOutput("bp_wb_wdata", 256'(m_wb_tdata.wdata), 256'(32'd5));
         checkOutput("bp_out_rfex_tready", 256'(s_rfex_tready), 256'(0));
      end
      @(posedge clk); #2;
      m_wb_tready = 1'b1;
      drainPipe("drain_bp");

      $display("[TB] back-to-back");
      b = mkBeat(32'h200, 1'b0, 1'b1, ALU_AND, 1'b0, BRU_BEQ, 32'hF0, 32'h3C, 32'h0);
      applyStimulus(b, 32'h30, mkBru(0, 0, 0), in_out);
      b = mkBeat(32'h204, 1'b0, 1'b0, ALU_ADD, 1'b0, BRU_BEQ, 32'h11, 32'h22, 32'h0);
      applyStimulus(b, 0, mkBru(0, 0, 0), in_out);
      checkOutput("b2b_accept_in_out", 256'(in_out), 256'(1));
      @(negedge clk);
      checkOutput("b2b_none_out", 256'(m_wb_tvalid), 256'(1));
      waitCycles(1);
      drainPipe("drain_b2b");

      $display("[TB] reset during WAIT");
      alu_delay = 6;
      b = mkBeat(32'h240, 1'b0, 1'b1, ALU_XOR, 1'b0, BRU_BEQ, 32'hFF, 32'h0F, 32'h0);
      applyStimulus(b, 32'hF0, mkBru(0, 0, 0), in_out);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_pre_wait", 256'(s_alu_tready), 256'(1));
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_alu_tready", 256'(s_alu_tready), 256'(0));
      checkOutput("rst_mid_wb_tvalid", 256'(m_wb_tvalid), 256'(0));
      checkOutput("rst_mid_rfex_tready", 256'(s_rfex_tready), 256'(0));
      checkOutput("rst_mid_wb_tdata", 256'(m_wb_tdata), 256'(0));
      checkOutput("rst_mid_redirect_pc", 256'(redirect_pc), 256'(0));
      wb_q.delete();
      exp_beats--;
      waitCycles(2);
      rst_n = 1'b1;
      alu_delay = 0;
      @(negedge clk);
      checkOutput("rst_restart_ready", 256'(s_rfex_tready), 256'(1));
      checkOutput("rst_restart_alu", 256'(m_alu_tvalid), 256'(0));
      waitCycles(1);
      b = mkBeat(32'h280, 1'b0, 1'b1, ALU_OR, 1'b0, BRU_BEQ, 32'h1, 32'h2, 32'h0);
      applyStimulus(b, 32'h3, mkBru(0, 0, 0), in_out);
      drainPipe("drain_restart");
      waitCycles(2);

      checkOutput("wb_count", 256'(wb_seen), 256'(exp_beats));
      checkOutput("alu_req_left", 256'(alu_req_q.size()), 256'(0));
      checkOutput("bru_req_left", 256'(bru_req_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/offnariscv_ex_sched.md
Name: offnariscv_ex_sched

Overview:
- Execute-stage scheduler. Accepts one rfex_tdata_t beat from the RF stage and dispatches it to the ALU or the BRU over valid/ready streams.
- Collects the unit result, builds a wbrf_tdata_t beat for writeback, and raises a one-cycle front-end redirect when a branch or jump is taken.
- At most one instruction is in flight. Sits between the RF stage and the WB stage of the offnariscv core.

Parameters:
- none; XLEN and all payload types come from offnariscv_pkg

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- s_rfex_tvalid  in  1  RF beat valid
- s_rfex_tready  out  1  scheduler can accept an RF beat
- s_rfex_tdata  in  $bits(rfex_tdata_t)  instruction plus operands
- m_alu_tvalid/m_alu_tready/m_alu_tdata  out/in/out  1/1/$bits(rfalu_tdata_t)  ALU request stream
- s_alu_tvalid/s_alu_tready/s_alu_tdata  in/out/in  1/1/$bits(aluwb_tdata_t)  ALU result stream
- m_bru_tvalid/m_bru_tready/m_bru_tdata  out/in/out  1/1/$bits(rfbru_tdata_t)  BRU request stream
- s_bru_tvalid/s_bru_tready/s_bru_tdata  in/out/in  1/1/$bits(bruwb_tdata_t)  BRU result stream
- m_wb_tvalid/m_wb_tready/m_wb_tdata  out/in/out  1/1/$bits(wbrf_tdata_t)  writeback stream
- redirect_valid  out  1  one-cycle pulse: fetch from redirect_pc
- redirect_pc  out  XLEN  target of the taken branch

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. Reset puts the FSM in IDLE; all valids, readies and redirect_valid are 0; all data registers are 0.
- Handshakes: a transfer occurs when tvalid && tready on a rising edge. Data registers update only on transfer. tvalid never drops without a handshake.
- Unit selection (sel), computed at accept time:
  - int_exc_valid=1 → NONE, even if a cmd_vld is set.
  - else bru_cmd_vld=1 → BRU (BRU wins if alu_cmd_vld is also 1).
  - else alu_cmd_vld=1 → ALU.
  - else → NONE.
- IDLE: s_rfex_tready=1. On handshake, latch the beat and sel; go to ISSUE, or to OUT with wdata=0 if sel=NONE.
- ISSUE: assert m_<sel>_tvalid.
  - ALU payload: operands, cmd=alu_cmd.
  - BRU payload: operands, offset=immediate, this_pc=if_data.pc, cmd=bru_cmd.
  - On handshake go to WAIT.
- WAIT: s_<sel>_tready=1. On handshake latch result, and for BRU also new_pc and taken; go to OUT. The other unit's tready stays 0.
- OUT: m_wb_tvalid=1; tdata.wdata=result, tdata.ex_data.rf_data=latched beat.
  - On m_wb handshake: go to IDLE; redirect_valid=1 for exactly that cycle if sel=BRU && taken, with redirect_pc=new_pc.
  - Back-to-back: s_rfex_tready=m_wb_tready in OUT. A simultaneous accept loads the new beat and goes straight to ISSUE/OUT.
- Latency with all readies high:
  - ALU/BRU: accept at cycle 0, ISSUE cycle 1, WAIT cycle 2 (a result valid that cycle is taken), m_wb_tvalid cycle 3.
  - NONE: m_wb_tvalid cycle 1.
- Backpressure: any stall in ISSUE, WAIT or OUT holds state and data indefinitely.
- redirect_pc holds its last value when redirect_valid=0.
- A result-stream valid outside WAIT, or from the unselected unit, is ignored: tready stays 0.

Optional Feature:
- Macro: OFFNARISCV_EX_SCHED_PERF_EN.
- When defined, adds three outputs, each 32-bit, reset to 0, incremented by 1 per cycle, wrapping at 2^32:
  - perf_busy_cycles: FSM != IDLE.
  - perf_unit_stall_cycles: ISSUE with the unit's tready=0, or WAIT with the unit's tvalid=0.
  - perf_wb_stall_cycles: OUT with m_wb_tready=0.
- When undefined, the ports and counters are absent.
- When SYNTHESIS is undefined, an assertion also flags alu_cmd_vld && bru_cmd_vld at accept time.

Decomposition:
- offnariscv_pkg gains:
  - ex_sched_state_e {IDLE, ISSUE, WAIT, OUT}
  - ex_unit_e {EXU_NONE, EXU_ALU, EXU_BRU}
- No sub-module. Request payload packing is combinational inside the block.

Test Plan:
- ALU add: op1=5, op2=7, alu_cmd_vld=1, all readies high → m_alu_tvalid at cycle 1; ALU returns 12 at cycle 2; m_wb wdata=12 at cycle 3; redirect_valid stays 0.
- Taken BEQ at pc=0x100: BRU returns taken=1, new_pc=0x120, result=0 → redirect_valid pulses for exactly the wb-handshake cycle with redirect_pc=0x120.
- Not-taken BNE → wb beat emitted; redirect_valid stays 0; redirect_pc is unchanged.
- Exception beat (int_exc_valid=1, alu_cmd_vld=1) → no m_alu_tvalid; m_wb_tvalid at cycle 1 with wdata=0.
- Backpressure: m_alu_tready=0 for 4 cycles, then m_wb_tready=0 for 3 cycles → payloads stable, s_rfex_tready=0 throughout; exactly one wb beat.
- Back-to-back: second rfex beat valid while OUT handshakes → accepted the same cycle. Assert rst_n low during WAIT → outputs 0 immediately; FSM restarts in IDLE.
